// File: rtl/rf_dump_pkg.sv
// Shared types and frame constants for the register-dump streamer.
// DUMP_HILO_EN adds the hi/lo words to the end of the frame.
package rf_dump_pkg;

  typedef enum logic [1:0] {RUN, CAPTURE, SEND, DONE} state_t;

  localparam logic [7:0] MARKER_TRIG = 8'hA5;
  localparam logic [7:0] MARKER_TMO  = 8'h5A;
  localparam int HDR_BYTES = 9;

`ifdef DUMP_HILO_EN
  localparam int HILO_WORDS = 2;
`else
  localparam int HILO_WORDS = 0;
`endif

  localparam int FRAME_BYTES = HDR_BYTES + 4 * 32 + 4 * HILO_WORDS;

endpackage

// File: rtl/rf_dump_streamer_if.sv
// Byte stream toward a UART TX or host FIFO; valid/ready handshake.
interface rf_dump_streamer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/rf_dump_streamer_byte_sender.sv
// Serialises one loaded word MSB-first onto the byte stream; len selects
// how many leading bytes go out (1 for the marker, 4 for full words).
module dump_byte_sender (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] word,
  input  logic [2:0]  len,
  output logic        busy,
  output logic        word_done,
  rf_dump_streamer_if.master stream
);

  logic [31:0] shreg;
  logic [2:0]  left;
  logic        valid;
  logic        fire;

  assign fire      = valid && stream.out_ready;
  assign word_done = fire && (left == 3'd1);
  assign busy      = valid;

  assign stream.out_valid = valid;
  assign stream.out_data  = shreg[31:24];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg <= '0;
      left  <= '0;
      valid <= 1'b0;
    end else if (load && !valid) begin
      shreg <= word;
      left  <= len;
      valid <= 1'b1;
    end else if (fire) begin
      shreg <= {shreg[23:0], 8'h00};
      left  <= left - 3'd1;
      if (left == 3'd1) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_dump_streamer.sv
// Halts the CPU on a trigger PC or run-cycle limit, then streams marker, PC,
// instr and x0..x(NUM_REGS-1) as a byte frame. DUMP_HILO_EN appends hi/lo.
//
// state   | meaning
// RUN     | CPU running, cycle counter advancing, watching for trigger/limit
// CAPTURE | one cycle: latch pc/instr(/hi/lo), pick marker and timeout flag
// SEND    | walk header words and registers through the byte sender
// DONE    | frame complete; CPU stays halted until reset
module rf_dump_streamer
  import rf_dump_pkg::*;
#(
  parameter logic [31:0] TRIGGER_PC = 32'h0000_0048,
  parameter int          MAX_CYCLES = 1000,
  parameter int          NUM_REGS   = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        cpu_halt,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
`ifdef DUMP_HILO_EN
  input  logic [31:0] hi,
  input  logic [31:0] lo,
`endif
  rf_dump_streamer_if.master stream,
  output logic        done,
  output logic        timeout
);

  // word order: marker, pc, instr, registers, then optional hi/lo
  localparam int NUM_WORDS = 3 + NUM_REGS + HILO_WORDS;
  localparam int WW        = $clog2(NUM_WORDS + 1);

  state_t        state, state_nxt;
  logic [15:0]   cycle_cnt;
  logic          trig_hit, limit_hit, tmo_pend;
  logic [31:0]   pc_q, instr_q;
  logic [7:0]    marker_q;
  logic [WW-1:0] widx;
  logic          load, busy, word_done;
  logic [31:0]   word;
  logic [2:0]    len;
`ifdef DUMP_HILO_EN
  logic [31:0]   hi_q, lo_q;
`endif

  assign trig_hit  = (pc == TRIGGER_PC);
  assign limit_hit = (cycle_cnt == 16'(MAX_CYCLES));
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    cpu_halt  = 1'b1;
    load      = 1'b0;
    case (state)
      RUN: begin
        cpu_halt = trig_hit || limit_hit;
        if (cpu_halt) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = SEND;
      SEND: begin
        load = !busy && (widx != WW'(NUM_WORDS));
        if (word_done && (widx == WW'(NUM_WORDS))) state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    word = '0;
    len  = 3'd4;
    if (widx == WW'(0)) begin
      word = {marker_q, 24'h0};
      len  = 3'd1;
    end else if (widx == WW'(1)) begin
      word = pc_q;
    end else if (widx == WW'(2)) begin
      word = instr_q;
    end else if (widx < WW'(3 + NUM_REGS)) begin
      word = (reg_sel == 5'd0) ? 32'h0 : reg_data;
    end
`ifdef DUMP_HILO_EN
    else if (widx == WW'(3 + NUM_REGS)) begin
      word = hi_q;
    end else begin
      word = lo_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RUN;
      cycle_cnt <= '0;
      tmo_pend  <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      marker_q  <= '0;
      timeout   <= 1'b0;
      widx      <= '0;
      reg_sel   <= '0;
`ifdef DUMP_HILO_EN
      hi_q      <= '0;
      lo_q      <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == RUN) begin
        if (!limit_hit) cycle_cnt <= cycle_cnt + 16'd1;
        // trigger wins when both fire in the same cycle
        tmo_pend <= !trig_hit;
      end
      if (state == CAPTURE) begin
        pc_q     <= pc;
        instr_q  <= instr;
        marker_q <= tmo_pend ? MARKER_TMO : MARKER_TRIG;
        timeout  <= tmo_pend;
`ifdef DUMP_HILO_EN
        hi_q     <= hi;
        lo_q     <= lo;
`endif
      end
      // reg_sel is set one word ahead so reg_data is settled at the load edge
      if (load) begin
        widx <= widx + WW'(1);
        if ((widx >= WW'(2)) && (widx < WW'(2 + NUM_REGS)))
          reg_sel <= 5'(widx - WW'(2));
        else
          reg_sel <= '0;
      end
      if (state_nxt == DONE) reg_sel <= '0;
    end
  end

  dump_byte_sender u_sender (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .word      (word),
    .len       (len),
    .busy      (busy),
    .word_done (word_done),
    .stream    (stream)
  );

endmodule

// File: tb/tb_rf_dump_streamer.sv
// Bench for rf_dump_streamer: CPU stub, frame model queue, per-cycle byte compare.
module tb_rf_dump_streamer;
  import rf_dump_pkg::*;

`ifdef DUMP_HILO_EN
  localparam int FRAME = 145;
`else
  localparam int FRAME = 137;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pc, instr;
  logic        halt_a, halt_b, done_a, done_b, tmo_a, tmo_b;
  logic [4:0]  reg_sel_a, reg_sel_b;
  logic [31:0] reg_data_a, reg_data_b;
  logic [31:0] regs [32];
  logic [31:0] hi = 32'hDEADBEEF;
  logic [31:0] lo = 32'h0BADF00D;
  bit          loop_mode = 1'b0;
  int          ready_pct = 0;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  got [160];
  int          nrx = 0;
  int          b_cnt = 0;
  logic [7:0]  b_first = 8'h00;

  rf_dump_streamer_if bus_a ();
  rf_dump_streamer_if bus_b ();

  always #5 clk = ~clk;

  // CPU stub: straight-line program, or a tight loop 0x10 <-> 0x14
  always @(posedge clk or negedge rstn) begin
    if (!rstn) pc <= 32'h0;
    else if (!halt_a) pc <= (loop_mode && pc == 32'h14) ? 32'h10 : pc + 32'd4;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return 32'h13 | (p << 12);
  endfunction

  assign instr      = instr_of(pc);
  assign reg_data_a = regs[reg_sel_a];
  assign reg_data_b = regs[reg_sel_b];
  assign bus_b.out_ready = 1'b1;

  rf_dump_streamer #(.TRIGGER_PC(32'h48), .MAX_CYCLES(1000), .NUM_REGS(32)) dut_a (
    .clk(clk), .rstn(rstn), .pc(pc), .instr(instr), .cpu_halt(halt_a),
    .reg_sel(reg_sel_a), .reg_data(reg_data_a),
`ifdef DUMP_HILO_EN
    .hi(hi), .lo(lo),
`endif
    .stream(bus_a.master), .done(done_a), .timeout(tmo_a));

  // limit of 18 coincides with PC 0x48 on the straight-line program
  rf_dump_streamer #(.TRIGGER_PC(32'h48), .MAX_CYCLES(18), .NUM_REGS(32)) dut_b (
    .clk(clk), .rstn(rstn), .pc(pc), .instr(instr), .cpu_halt(halt_b),
    .reg_sel(reg_sel_b), .reg_data(reg_data_b),
`ifdef DUMP_HILO_EN
    .hi(hi), .lo(lo),
`endif
    .stream(bus_b.master), .done(done_b), .timeout(tmo_b));

  always @(negedge clk or negedge rstn) begin
    if (!rstn) b_cnt = 0;
    else if (bus_b.out_valid) begin
      if (b_cnt == 0) b_first = bus_b.out_data;
      b_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic build_exp(input logic [7:0] mk, input logic [31:0] p);
    exp_q.delete();
    exp_q.push_back(mk);
    push_word(p);
    push_word(instr_of(p));
    for (int k = 0; k < 32; k++) push_word(k == 0 ? 32'h0 : regs[k]);
`ifdef DUMP_HILO_EN
    push_word(hi);
    push_word(lo);
`endif
  endtask

  task automatic monitor();
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("rst_valid", {31'h0, bus_a.out_valid}, 32'h0);
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("hold_valid", {31'h0, bus_a.out_valid}, 32'h1);
          chk("hold_data", {24'h0, bus_a.out_data}, {24'h0, pd});
        end
        if (bus_a.out_valid && bus_a.out_ready) begin
          if (exp_q.size() == 0) chk("extra_byte", {24'h0, bus_a.out_data}, 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("byte", {24'h0, bus_a.out_data}, {24'h0, e});
          end
          if (nrx < 160) got[nrx] = bus_a.out_data;
          nrx++;
        end
        pv = bus_a.out_valid; pr = bus_a.out_ready; pd = bus_a.out_data;
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk); #1;
      bus_a.out_ready = (ready_pct >= 100) ? 1'b1 :
                        (int'($urandom_range(0, 99)) < ready_pct);
    end
  endtask

  task automatic start_run(input bit lp, input int pct, input int exp_n,
                           input logic [31:0] exp_pc, input logic [7:0] mk);
    int n;
    rstn = 1'b0; ready_pct = 0; loop_mode = lp;
    repeat (2) @(posedge clk);
    nrx = 0;
    build_exp(mk, exp_pc);
    ready_pct = pct;
    @(negedge clk); rstn = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(posedge clk); n++; #1;
      if (halt_a) break;
    end
    chk("halt_cycle", n, exp_n);
    chk("halt_pc", pc, exp_pc);
  endtask

  task automatic finish_run(input logic [31:0] exp_pc, input bit exp_tmo);
    int k = 0;
    while (!done_a && k < 20000) begin @(negedge clk); k++; end
    chk("done", {31'h0, done_a}, 32'h1);
    chk("frame_len", nrx, FRAME);
    chk("model_left", exp_q.size(), 0);
    chk("timeout", {31'h0, tmo_a}, {31'h0, exp_tmo});
    chk("halt_held", {31'h0, halt_a}, 32'h1);
    chk("pc_frozen", pc, exp_pc);
    chk("reg_sel_done", {27'h0, reg_sel_a}, 32'h0);
    chk("valid_done", {31'h0, bus_a.out_valid}, 32'h0);
  endtask

  initial begin
    int k;
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101;
    regs[0] = 32'hCAFEBABE; regs[1] = 32'h1111_1111; regs[31] = 32'hFFFF_FFFF;
    fork monitor(); drive_ready(); join_none

    // reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_data", {24'h0, bus_a.out_data}, 32'h0);
    chk("rst_done", {31'h0, done_a}, 32'h0);
    chk("rst_timeout", {31'h0, tmo_a}, 32'h0);
    chk("rst_reg_sel", {27'h0, reg_sel_a}, 32'h0);
    chk("rst_halt", {31'h0, halt_a}, 32'h0);

    // trigger at PC 0x48, sink always ready
    start_run(1'b0, 100, 18, 32'h48, 8'hA5);
    finish_run(32'h48, 1'b0);
    chk("lit_b0", {24'h0, got[0]}, 32'hA5);
    chk("lit_b4", {24'h0, got[4]}, 32'h48);
    chk("lit_instr", {got[5], got[6], got[7], got[8]}, 32'h0004_8013);
    chk("lit_x0", {got[9], got[10], got[11], got[12]}, 32'h0);
    chk("lit_x1", {got[13], got[14], got[15], got[16]}, 32'h1111_1111);
    chk("lit_x31", {got[133], got[134], got[135], got[136]}, 32'hFFFF_FFFF);
`ifdef DUMP_HILO_EN
    chk("lit_hi", {got[137], got[138], got[139], got[140]}, 32'hDEAD_BEEF);
    chk("lit_lo", {got[141], got[142], got[143], got[144]}, 32'h0BAD_F00D);
`endif
    // limit and trigger coincide on dut_b
    chk("coinc_marker", {24'h0, b_first}, 32'hA5);
    chk("coinc_timeout", {31'h0, tmo_b}, 32'h0);
    chk("coinc_len", b_cnt, FRAME);
    chk("coinc_done", {31'h0, done_b}, 32'h1);

    // same frame under a 30% ready duty
    start_run(1'b0, 30, 18, 32'h48, 8'hA5);
    finish_run(32'h48, 1'b0);

    // reset two cycles after the 40th accepted byte
    start_run(1'b0, 100, 18, 32'h48, 8'hA5);
    k = 0;
    while (nrx < 40 && k < 1000) begin @(posedge clk); k++; end
    chk("reach_40", {31'h0, nrx >= 40}, 32'h1);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b0; #1;
    chk("abort_valid", {31'h0, bus_a.out_valid}, 32'h0);
    chk("abort_data", {24'h0, bus_a.out_data}, 32'h0);
    chk("abort_done", {31'h0, done_a}, 32'h0);
    start_run(1'b0, 100, 18, 32'h48, 8'hA5);
    finish_run(32'h48, 1'b0);

    // tight loop: cycle limit forces a timeout dump
    start_run(1'b1, 100, 1000, 32'h10, 8'h5A);
    finish_run(32'h10, 1'b1);
    chk("tmo_lit_b0", {24'h0, got[0]}, 32'h5A);
    chk("tmo_lit_pc", {got[1], got[2], got[3], got[4]}, 32'h10);
    chk("b_tmo_marker", {24'h0, b_first}, 32'h5A);
    chk("b_tmo_flag", {31'h0, tmo_b}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
